// File: rtl/win_detector_if.sv
// Board / result bundle between the move-commit logic (master) and the
// round-result stage (slave).
//   boardX, boardO : 9-bit cell occupancy per player, cell = row*3 + col
//   move_valid     : strobe, the boards now include a newly committed move
//   new_round      : strobe, clear the held result and start a new round
//   incrementX/O   : registered one-cycle score pulses
//   winner, draw, illegal, game_over, win_line, move_count : held result
interface win_detector_if;
    logic [8:0] boardX;
    logic [8:0] boardO;
    logic       move_valid;
    logic       new_round;
    logic       incrementX;
    logic       incrementO;
    logic [1:0] winner;
    logic       draw;
    logic       illegal;
    logic       game_over;
    logic [7:0] win_line;
    logic [3:0] move_count;

    modport master (
        output boardX, boardO, move_valid, new_round,
        input  incrementX, incrementO, winner, draw, illegal,
               game_over, win_line, move_count
    );

    modport slave (
        input  boardX, boardO, move_valid, new_round,
        output incrementX, incrementO, winner, draw, illegal,
               game_over, win_line, move_count
    );
endinterface

// File: rtl/win_detector.sv
// Round-result stage for a 3x3 board. Latches the board on each accepted
// move, evaluates it for one cycle and either returns to play or latches a
// result (X win, O win, draw, illegal) until new_round or reset.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   wd    : board inputs and result outputs (win_detector_if.slave)
module win_detector (
    input  logic                 clk,
    input  logic                 rst_n,
    win_detector_if.slave        wd
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        EVAL = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [8:0] bx_r, bx_s;
    logic [8:0] bo_r, bo_s;
    logic [3:0] cnt_r, cnt_s;
    logic [1:0] winner_r, winner_s;
    logic       draw_r, draw_s;
    logic       illegal_r, illegal_s;
    logic       over_r, over_s;
    logic [7:0] line_r, line_s;
    logic       incx_r, incx_s;
    logic       inco_r, inco_s;
    logic [7:0] xl_s;
    logic [7:0] ol_s;

    // Completed lines of one player: bits 0-2 rows, 3-5 columns, 6 diag, 7 anti-diag.
    function automatic logic [7:0] line_hits(input logic [8:0] b);
        return {b[2] & b[4] & b[6],
                b[0] & b[4] & b[8],
                b[2] & b[5] & b[8],
                b[1] & b[4] & b[7],
                b[0] & b[3] & b[6],
                &b[8:6],
                &b[5:3],
                &b[2:0]};
    endfunction

    assign xl_s = line_hits(bx_r);
    assign ol_s = line_hits(bo_r);

    // Next-state and next-result logic; new_round overrides every state.
    always_comb begin
        state_s   = state_r;
        bx_s      = bx_r;
        bo_s      = bo_r;
        cnt_s     = cnt_r;
        winner_s  = winner_r;
        draw_s    = draw_r;
        illegal_s = illegal_r;
        over_s    = over_r;
        line_s    = line_r;
        incx_s    = 1'b0;
        inco_s    = 1'b0;
        if (wd.new_round) begin
            state_s   = PLAY;
            cnt_s     = 4'd0;
            winner_s  = 2'b00;
            draw_s    = 1'b0;
            illegal_s = 1'b0;
            over_s    = 1'b0;
            line_s    = 8'd0;
        end else begin
            case (state_r)
                PLAY: begin
                    if (wd.move_valid) begin
                        bx_s    = wd.boardX;
                        bo_s    = wd.boardO;
                        cnt_s   = (cnt_r == 4'd9) ? 4'd9 : cnt_r + 4'd1;
                        state_s = EVAL;
                    end else begin
                        state_s = PLAY;
                    end
                end
                EVAL: begin
                    // Overlap or a double winner both mean the board is corrupt.
                    if (((bx_r & bo_r) != 9'd0) || ((xl_s != 8'd0) && (ol_s != 8'd0))) begin
                        illegal_s = 1'b1;
                        line_s    = 8'd0;
                        over_s    = 1'b1;
                        state_s   = OVER;
                    end else if (xl_s != 8'd0) begin
                        winner_s = 2'b01;
                        incx_s   = 1'b1;
                        line_s   = xl_s;
                        over_s   = 1'b1;
                        state_s  = OVER;
                    end else if (ol_s != 8'd0) begin
                        winner_s = 2'b10;
                        inco_s   = 1'b1;
                        line_s   = ol_s;
                        over_s   = 1'b1;
                        state_s  = OVER;
                    end else if (cnt_r == 4'd9) begin
                        draw_s  = 1'b1;
                        over_s  = 1'b1;
                        state_s = OVER;
                    end else begin
                        state_s = PLAY;
                    end
                end
                OVER: begin
                    state_s = OVER;
                end
                default: begin
                    state_s = PLAY;
                end
            endcase
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= PLAY;
            bx_r      <= 9'd0;
            bo_r      <= 9'd0;
            cnt_r     <= 4'd0;
            winner_r  <= 2'b00;
            draw_r    <= 1'b0;
            illegal_r <= 1'b0;
            over_r    <= 1'b0;
            line_r    <= 8'd0;
            incx_r    <= 1'b0;
            inco_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bx_r      <= bx_s;
            bo_r      <= bo_s;
            cnt_r     <= cnt_s;
            winner_r  <= winner_s;
            draw_r    <= draw_s;
            illegal_r <= illegal_s;
            over_r    <= over_s;
            line_r    <= line_s;
            incx_r    <= incx_s;
            inco_r    <= inco_s;
        end
    end

    assign wd.incrementX = incx_r;
    assign wd.incrementO = inco_r;
    assign wd.winner     = winner_r;
    assign wd.draw       = draw_r;
    assign wd.illegal    = illegal_r;
    assign wd.game_over  = over_r;
    assign wd.win_line   = line_r;
    assign wd.move_count = cnt_r;

endmodule

// File: doc/win_detector.md
# win_detector

Round-result stage feeding the score counter. Samples the committed 3x3 board after every accepted move, detects an X win, an O win, a draw or an illegal board, and emits the registered single-cycle `incrementX` / `incrementO` pulses that drive the score counter's rising-edge inputs. Holds the result (winner, winning lines, game over) for the display logic until a new round is requested.

## Interface
Parameters:
- none; board fixed at 3x3, cell index = row*3 + col (row 0 = top, col 0 = left).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `boardX`  in  9  cell occupancy for X (bit i = cell i).
- `boardO`  in  9  cell occupancy for O.
- `move_valid`  in  1  one-cycle strobe: board inputs now include a newly committed move.
- `new_round`  in  1  one-cycle strobe: clear result, start a new round.
- `incrementX`  out  1  registered one-cycle pulse on X win.
- `incrementO`  out  1  registered one-cycle pulse on O win.
- `winner`  out  2  00 none, 01 X, 10 O; held while game over.
- `draw`  out  1  board full with no winner; held.
- `illegal`  out  1  overlapping cells or both players winning; held.
- `game_over`  out  1  result latched; moves ignored.
- `win_line`  out  8  winning lines, bits 0-2 rows top..bottom, 3-5 columns left..right, 6 diagonal (0,4,8), 7 anti-diagonal (2,4,6).
- `move_count`  out  4  accepted moves this round, 0..9.

## Operation
- FSM states: PLAY, EVAL, OVER. Reset state PLAY.
- PLAY: on `move_valid`, latch `boardX`/`boardO` into internal registers, `move_count` += 1, go EVAL. Otherwise hold.
- EVAL (exactly one cycle), evaluated on latched board, priority order:
  1. `(bx & bo) != 0` or X and O both complete a line -> `illegal`=1, no pulse, `win_line`=0, go OVER.
  2. X completes >=1 line -> `winner`=01, `incrementX` pulse, `win_line` = all X lines, go OVER.
  3. O completes >=1 line -> `winner`=10, `incrementO` pulse, `win_line` = all O lines, go OVER.
  4. `move_count` == 9 -> `draw`=1, go OVER.
  5. else back to PLAY.
- OVER: `game_over`=1; `move_valid` ignored (no latch, no count). Leaves only via `new_round` or reset.
- `new_round` in any state: next state PLAY, `move_count`=0, `winner`=00, `draw`=`illegal`=`game_over`=0, `win_line`=0, pulses forced 0. An EVAL aborted by `new_round` produces no pulse.
- `new_round` and `move_valid` same cycle: `new_round` wins, move dropped.
- `move_valid` during EVAL: ignored.
- Double line by one player (e.g. row + diagonal on one move): several `win_line` bits set, still exactly one increment pulse.
- `move_count` saturates at 9; a `move_valid` in PLAY with `move_count`==9 is impossible by construction (EVAL exits to OVER).

## Timing
- Reset (`rst_n`=0 at a rising edge): all outputs 0, state PLAY, latched board 0. Reset dominates `new_round` and `move_valid`.
- `move_valid` sampled at edge n -> EVAL during cycle n..n+1 -> at edge n+1 result registers update: `incrementX`/`incrementO` high for cycle n+1..n+2 only, `winner`/`draw`/`illegal`/`win_line`/`game_over` high from edge n+1 and held.
- `move_count` updates at edge n (same edge as latch).
- Latency move_valid -> increment pulse: 2 edges. Accepted move rate: one per 2 cycles max (PLAY->EVAL->PLAY).
- Pulses are flop outputs, glitch-free, low at least one cycle between any two pulses (at most one pulse per round).

## Test plan
- Reset then X fills cells 0,1,2 with O on 3,4 (5 `move_valid` strobes, 2+ cycles apart) -> after fifth move `incrementX` high exactly one cycle, `winner`=01, `win_line`=8'b00000001, `move_count`=5, `incrementO` never high.
- O wins anti-diagonal 2,4,6 on move 6 -> `incrementO` one cycle, `winner`=10, `win_line`=8'b10000000; further `move_valid` in OVER leaves `move_count`=6.
- Full board no line (X 0,2,3,7,8 / O 1,4,5,6) -> `draw`=1, `game_over`=1, no pulses, `move_count`=9.
- X move 9 completing row 0 and diagonal -> `win_line`=8'b01000001, single `incrementX` pulse.
- `boardX`=`boardO`=9'h001 with `move_valid` -> `illegal`=1, no pulses; then `new_round` -> all outputs 0, next move accepted with `move_count`=1.
- `new_round` asserted during EVAL of a winning move -> no pulse, PLAY, `move_count`=0; `rst_n`=0 in OVER -> all outputs 0 next edge.
